spi_slave_responder: RTL and testbench
======================================

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter CHAR_LEN, default 8, bits per frame (legal 4..32).
REQ-002 Parameter CPOL, default 0, idle level of sclk.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = bit CHAR_LEN-1 shifted first, 0 = bit 0 first.
REQ-005 Parameter IDLE_PATTERN, default all-zero (CHAR_LEN bits), miso data when no TX word is queued.
REQ-006 pclk  input  1  system clock; sole clock of the block.
REQ-007 areset  input  1  reset, synchronous to pclk, active-low.
REQ-008 sclk  input  1  SPI clock from master, asynchronous to pclk.
REQ-009 cs  input  1  active-low chip select from master, asynchronous.
REQ-010 mosi0  input  1  master-out slave-in serial data, asynchronous.
REQ-011 miso0  output  1  master-in slave-out serial data.
REQ-012 miso_oe  output  1  miso0 output enable, high while selected.
REQ-013 tx_data  input  CHAR_LEN  word to transmit in a coming frame.
REQ-014 tx_valid  input  1  tx_data valid.
REQ-015 tx_ready  output  1  holding register empty; transfer occurs when tx_valid && tx_ready.
REQ-016 rx_data  output  CHAR_LEN  last complete received word.
REQ-017 rx_valid  output  1  one-pclk pulse, rx_data updated.
REQ-018 tx_underrun  output  1  one-pclk pulse, frame started with empty holding register.
REQ-019 frame_err  output  1  one-pclk pulse, cs deasserted mid-frame.

Function
REQ-020 sclk, cs, mosi0 each pass through a 2-flop pclk synchronizer; a third flop on sclk and cs provides edge detection; a raw pin edge is acted on in the 3rd pclk cycle after it.
REQ-021 Legal operation requires sclk high and low phases each >= 4 pclk periods; behaviour outside this is undefined.
REQ-022 FSM states: IDLE, SHIFT; IDLE -> SHIFT on detected cs fall; SHIFT -> IDLE on detected cs rise.
REQ-023 On IDLE -> SHIFT: shift register loaded from holding register (holding register emptied, tx_ready rises next cycle) or from IDLE_PATTERN with tx_underrun pulsed if empty; bit counter cleared.
REQ-024 Leading edge = rising if CPOL=0 else falling; sample edge = leading if CPHA=0 else trailing; shift edge = the other.
REQ-025 CPHA=0: first TX bit on miso0 in the cycle after the load; subsequent bits change on shift edges.
REQ-026 CPHA=1: miso0 changes on every shift edge including the first; first TX bit appears on the first leading edge.
REQ-027 On each detected sample edge: synchronized mosi0 captured into RX shift register in MSB_FIRST order; bit counter increments.
REQ-028 When the counter reaches CHAR_LEN: rx_data updated and rx_valid pulsed in the following pclk cycle; counter wraps to 0; TX shift register reloaded per REQ-023 (back-to-back frames within one cs).
REQ-029 Detected cs rise with counter != 0: partial word discarded, rx_data unchanged, frame_err pulsed, counter cleared.
REQ-030 Detected cs rise with counter == 0: return to IDLE silently.
REQ-031 Holding register accepts tx_valid && tx_ready in any state; load into shift register and a new write in the same cycle: shift register takes the old word, holding register takes the new one, tx_ready stays low.
REQ-032 sclk edges while in IDLE are ignored.
REQ-033 miso_oe equals synchronized cs inverted while in SHIFT; miso0 forced 0 when miso_oe is 0.

Reset
REQ-034 areset low at a pclk rising edge: FSM IDLE, counter 0, shift registers 0, holding register empty, synchronizer flops set to cs=1, sclk=CPOL, mosi0=0.
REQ-035 Reset values: miso0=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0.
REQ-036 Reset asserted mid-frame aborts the frame without frame_err; after release the block waits for a fresh cs fall.

Verification
REQ-037 Mode 0, CHAR_LEN=8, tx_data=0xA5 queued, master sends 0x3C -> miso0 bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse.
REQ-038 Modes 1,2,3 each with tx 0x81 / rx 0x7E -> correct data both directions, LSB-first variant with MSB_FIRST=0.
REQ-039 No word queued, frame started -> tx_underrun pulse, miso0 carries IDLE_PATTERN, rx still received.
REQ-040 cs raised after 5 of 8 bits -> frame_err pulse, no rx_valid, rx_data unchanged; next full frame correct.
REQ-041 16 clocks in one cs, two words queued (0x11 then 0x22) -> miso0 sends 0x11,0x22; two rx_valid pulses.
REQ-042 areset low at bit 4 -> all outputs at reset values next cycle; subsequent frame correct, no frame_err.

Source files
------------

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: pclk-oversampled SPI slave with a one-word TX holding register and RX word output
module spi_slave_responder #(
    parameter int                  CHAR_LEN     = 8,
    parameter bit                  CPOL         = 1'b0,
    parameter bit                  CPHA         = 1'b0,
    parameter bit                  MSB_FIRST    = 1'b1,
    parameter logic [CHAR_LEN-1:0] IDLE_PATTERN = '0
) (
    input  logic                pclk,
    input  logic                areset,
    input  logic                sclk,
    input  logic                cs,
    input  logic                mosi0,
    output logic                miso0,
    output logic                miso_oe,
    input  logic [CHAR_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [CHAR_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                tx_underrun,
    output logic                frame_err
);
    localparam int CW = $clog2(CHAR_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAR_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_next;

    logic [2:0] sclk_s, cs_s;
    logic [1:0] mosi_s;
    logic [CHAR_LEN-1:0] tx_sr, rx_sr, hold, rx_next, load_word, tx_shifted;
    logic [CW-1:0] cnt;
    logic hold_full, out_bit, tx_bit;
    logic lead, trail, sample, shift, cs_fall, cs_rise, start, end_frame, wrap, load, write, do_shift;

    always_comb begin
        lead       = CPOL ? (sclk_s[2] & ~sclk_s[1]) : (~sclk_s[2] & sclk_s[1]);
        trail      = (sclk_s[2] ^ sclk_s[1]) & ~lead;
        sample     = CPHA ? trail : lead;
        shift      = CPHA ? lead : trail;
        cs_fall    = cs_s[2] & ~cs_s[1];
        cs_rise    = ~cs_s[2] & cs_s[1];
        start      = (state == IDLE) && cs_fall;
        end_frame  = (state == SHIFT) && cs_rise;
        wrap       = (state == SHIFT) && !cs_rise && sample && (cnt == LAST);
        load       = start | wrap;
        write      = tx_valid & ~hold_full;
        // with CPHA=0 the trailing edge right after a word boundary must not disturb the freshly loaded word
        do_shift   = (state == SHIFT) && !cs_rise && shift && (CPHA || cnt != '0);
        rx_next    = MSB_FIRST ? {rx_sr[CHAR_LEN-2:0], mosi_s[1]} : {mosi_s[1], rx_sr[CHAR_LEN-1:1]};
        load_word  = hold_full ? hold : IDLE_PATTERN;
        tx_bit     = MSB_FIRST ? tx_sr[CHAR_LEN-1] : tx_sr[0];
        tx_shifted = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
        state_next = start ? SHIFT : end_frame ? IDLE : state;
        miso_oe    = (state == SHIFT) && !cs_s[1];
        miso0      = miso_oe & (CPHA ? out_bit : tx_bit);
        tx_ready   = ~hold_full;
    end

    always_ff @(posedge pclk)
        if (!areset) state <= IDLE;
        else state <= state_next;

    always_ff @(posedge pclk) begin
        if (!areset) begin
            sclk_s      <= {3{CPOL}};
            cs_s        <= 3'b111;
            mosi_s      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            out_bit     <= 1'b0;
            cnt         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sclk_s      <= {sclk_s[1:0], sclk};
            cs_s        <= {cs_s[1:0], cs};
            mosi_s      <= {mosi_s[0], mosi0};
            rx_valid    <= wrap;
            tx_underrun <= load & ~hold_full;
            frame_err   <= end_frame && (cnt != '0);
            hold_full   <= write | (hold_full & ~load);
            if (write) hold <= tx_data;
            if (load) tx_sr <= load_word;
            else if (do_shift) tx_sr <= tx_shifted;
            if (start) out_bit <= 1'b0;
            else if (do_shift) out_bit <= tx_bit;
            if (start || end_frame) cnt <= '0;
            else if (state == SHIFT && sample) cnt <= wrap ? '0 : cnt + CW'(1);
            if (state == SHIFT && sample && !cs_rise) rx_sr <= rx_next;
            if (wrap) rx_data <= rx_next;
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: five responder variants driven by a behavioural SPI master
module tb_spi_slave_responder;
    localparam int H = 6;
    localparam logic [4:0] CPOL_V = 5'b01100;
    localparam logic [4:0] CPHA_V = 5'b01010;
    localparam logic [4:0] MSB_V  = 5'b01111;

    typedef struct {
        int d; int n; logic [7:0] tx; bit q; logic [7:0] mo;
        logic [7:0] e_rx; logic [7:0] e_m; int e_v; int e_u; int e_e;
    } vec_t;

    logic pclk = 1'b0, areset = 1'b0, sc = 1'b0, mosi = 1'b0;
    logic [4:0] cs_v = '1, tx_valid_v = '0;
    logic [7:0] tx_data = '0;
    wire [4:0] miso_v, oe_v, ready_v, rxv_v, und_v, err_v;
    wire [4:0][7:0] rxd;
    int nv[5], nu[5], ne[5];
    int pass = 0, total = 0;
    logic mosi_bits[32], miso_bits[32];
    logic [7:0] txq[$];
    logic [7:0] exp_rx[5];
    logic got_oe;

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < 5; g++) begin : u
        spi_slave_responder #(
            .CHAR_LEN(8), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]), .MSB_FIRST(MSB_V[g]),
            .IDLE_PATTERN(g == 4 ? 8'hC3 : 8'h00)
        ) dut (
            .pclk(pclk), .areset(areset), .sclk(sc ^ CPOL_V[g]), .cs(cs_v[g]), .mosi0(mosi),
            .miso0(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(tx_data), .tx_valid(tx_valid_v[g]),
            .tx_ready(ready_v[g]), .rx_data(rxd[g]), .rx_valid(rxv_v[g]),
            .tx_underrun(und_v[g]), .frame_err(err_v[g])
        );
    end

    always @(negedge pclk)
        for (int i = 0; i < 5; i++) begin
            nv[i] += int'(rxv_v[i]);
            nu[i] += int'(und_v[i]);
            ne[i] += int'(err_v[i]);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [7:0] word(input int d, input int k, input bit from_miso);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[MSB_V[d] ? 7 - j : j] = from_miso ? miso_bits[8*k+j] : mosi_bits[8*k+j];
        return r;
    endfunction

    task automatic fill_mosi(input int d, input logic [7:0] w0, input logic [7:0] w1);
        for (int b = 0; b < 16; b++) mosi_bits[b] = b < 8 ? w0[MSB_V[d] ? 7 - b : b] : w1[MSB_V[d] ? 15 - b : b - 8];
    endtask

    task automatic xfer(input int d, input int n);
        @(negedge pclk);
        cs_v[d] = 1'b0;
        if (!CPHA_V[d]) mosi = mosi_bits[0];
        repeat (8) @(negedge pclk);
        got_oe = oe_v[d];
        for (int b = 0; b < n; b++) begin
            if (CPHA_V[d]) begin
                mosi = mosi_bits[b]; sc = 1'b1; repeat (H) @(negedge pclk);
                miso_bits[b] = miso_v[d]; sc = 1'b0; repeat (H) @(negedge pclk);
            end else begin
                miso_bits[b] = miso_v[d]; sc = 1'b1; repeat (H) @(negedge pclk);
                sc = 1'b0;
                if (b + 1 < n) mosi = mosi_bits[b+1];
                repeat (H) @(negedge pclk);
            end
        end
        repeat (4) @(negedge pclk);
        cs_v[d] = 1'b1;
        repeat (8) @(negedge pclk);
    endtask

    task automatic do_write(input int d, input logic [7:0] w);
        int t = 0;
        while (!ready_v[d] && t < 50) begin @(negedge pclk); t++; end
        chk("tx_ready_wait", 32'(ready_v[d]), 32'd1);
        tx_data = w; tx_valid_v[d] = 1'b1;
        @(negedge pclk);
        tx_valid_v[d] = 1'b0;
        chk("tx_ready_low", 32'(ready_v[d]), 32'd0);
        txq.push_back(w);
    endtask

    task automatic xact(input int d, input int n, input bit mid, input logic [7:0] mid_w,
                        output logic [7:0] rx, output int v, output int un, output int e,
                        output logic [7:0] m0, output logic [7:0] m1);
        int v0 = nv[d], u0 = nu[d], e0 = ne[d];
        fork
            xfer(d, n);
            begin if (mid) begin repeat (30) @(negedge pclk); do_write(d, mid_w); end end
        join
        rx = rxd[d]; v = nv[d] - v0; un = nu[d] - u0; e = ne[d] - e0;
        m0 = word(d, 0, 1'b1); m1 = word(d, 1, 1'b1);
        chk("oe_in_frame", 32'(got_oe), 32'd1);
        chk("oe_after", 32'(oe_v[d]), 32'd0);
        chk("miso_after", 32'(miso_v[d]), 32'd0);
    endtask

    initial begin
        logic [7:0] rx, m0, m1, w0, w1, w;
        int v, un, e, e0, d, r, n, words, und;
        vec_t tv[12];
        tv[0]  = '{0, 8, 8'hA5, 1'b1, 8'h3C, 8'h3C, 8'hA5, 1, 1, 0};
        tv[1]  = '{1, 8, 8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81, 1, 1, 0};
        tv[2]  = '{2, 8, 8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81, 1, 1, 0};
        tv[3]  = '{3, 8, 8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81, 1, 1, 0};
        tv[4]  = '{4, 8, 8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81, 1, 1, 0};
        tv[5]  = '{4, 8, 8'h12, 1'b1, 8'h34, 8'h34, 8'h12, 1, 1, 0};
        tv[6]  = '{0, 8, 8'h00, 1'b0, 8'h5A, 8'h5A, 8'h00, 1, 2, 0};
        tv[7]  = '{4, 8, 8'h00, 1'b0, 8'h96, 8'h96, 8'hC3, 1, 2, 0};
        tv[8]  = '{0, 5, 8'h66, 1'b1, 8'hFF, 8'h5A, 8'h00, 0, 0, 1};
        tv[9]  = '{0, 8, 8'h99, 1'b1, 8'hC4, 8'hC4, 8'h99, 1, 1, 0};
        tv[10] = '{3, 3, 8'h00, 1'b0, 8'hFF, 8'h7E, 8'h00, 0, 1, 1};
        tv[11] = '{3, 8, 8'hE7, 1'b1, 8'h18, 8'h18, 8'hE7, 1, 1, 0};

        repeat (5) @(negedge pclk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst%0d_ready", i), 32'(ready_v[i]), 32'd1);
            chk($sformatf("rst%0d_rx", i), 32'(rxd[i]), 32'd0);
            chk($sformatf("rst%0d_oe_miso", i), 32'({oe_v[i], miso_v[i]}), 32'd0);
        end
        chk("rst_pulses", 32'(rxv_v | und_v | err_v), 32'd0);
        areset = 1'b1;
        repeat (4) @(negedge pclk);

        foreach (tv[i]) begin
            if (tv[i].q) do_write(tv[i].d, tv[i].tx);
            fill_mosi(tv[i].d, tv[i].mo, 8'h00);
            xact(tv[i].d, tv[i].n, 1'b0, 8'h00, rx, v, un, e, m0, m1);
            chk($sformatf("vec%0d_rx", i), 32'(rx), 32'(tv[i].e_rx));
            chk($sformatf("vec%0d_rx_valid", i), 32'(v), 32'(tv[i].e_v));
            chk($sformatf("vec%0d_underrun", i), 32'(un), 32'(tv[i].e_u));
            chk($sformatf("vec%0d_frame_err", i), 32'(e), 32'(tv[i].e_e));
            if (tv[i].n >= 8) chk($sformatf("vec%0d_miso", i), 32'(m0), 32'(tv[i].e_m));
            txq.delete();
        end

        do_write(0, 8'h11);
        fill_mosi(0, 8'hA1, 8'h5B);
        xact(0, 16, 1'b1, 8'h22, rx, v, un, e, m0, m1);
        chk("b2b_miso0", 32'(m0), 32'h11);
        chk("b2b_miso1", 32'(m1), 32'h22);
        chk("b2b_rx_valid", 32'(v), 32'd2);
        chk("b2b_underrun", 32'(un), 32'd1);
        chk("b2b_frame_err", 32'(e), 32'd0);
        chk("b2b_rx", 32'(rx), 32'h5B);
        txq.delete();

        do_write(0, 8'h3D);
        fill_mosi(0, 8'hF0, 8'h00);
        e0 = ne[0];
        fork
            xfer(0, 8);
            begin
                repeat (8 + 8 * H + 3) @(negedge pclk);
                chk("pre_rst_oe", 32'(oe_v[0]), 32'd1);
                areset = 1'b0;
                @(negedge pclk);
                chk("mid_rst_oe_miso", 32'({oe_v[0], miso_v[0]}), 32'd0);
                chk("mid_rst_ready", 32'(ready_v[0]), 32'd1);
                chk("mid_rst_rx", 32'(rxd[0]), 32'd0);
                chk("mid_rst_pulses", 32'({rxv_v[0], und_v[0], err_v[0]}), 32'd0);
            end
        join
        areset = 1'b1;
        repeat (4) @(negedge pclk);
        chk("mid_rst_no_frame_err", 32'(ne[0] - e0), 32'd0);
        txq.delete();
        for (int i = 0; i < 5; i++) exp_rx[i] = 8'h00;
        do_write(0, 8'h42);
        fill_mosi(0, 8'h24, 8'h00);
        xact(0, 8, 1'b0, 8'h00, rx, v, un, e, m0, m1);
        chk("post_rst_rx", 32'(rx), 32'h24);
        chk("post_rst_miso", 32'(m0), 32'h42);
        chk("post_rst_frame_err", 32'(e), 32'd0);
        chk("post_rst_rx_valid", 32'(v), 32'd1);
        txq.delete();
        exp_rx[0] = 8'h24;

        for (int it = 0; it < 24; it++) begin
            d = $urandom_range(0, 4);
            r = $urandom_range(0, 7);
            n = r < 5 ? 8 : r < 7 ? 16 : $urandom_range(1, 15);
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(d, 8'($urandom));
            fill_mosi(d, w0, w1);
            xact(d, n, 1'b0, 8'h00, rx, v, un, e, m0, m1);
            words = n / 8;
            und = 0;
            // one load at the cs fall plus one at every completed word
            for (int k = 0; k <= words; k++) begin
                if (txq.size() > 0) w = txq.pop_front();
                else begin w = d == 4 ? 8'hC3 : 8'h00; und++; end
                if (k < words) chk($sformatf("rnd%0d_miso%0d", it, k), 32'(k == 0 ? m0 : m1), 32'(w));
            end
            if (words > 0) exp_rx[d] = words == 2 ? w1 : w0;
            chk($sformatf("rnd%0d_rx", it), 32'(rx), 32'(exp_rx[d]));
            chk($sformatf("rnd%0d_rx_valid", it), 32'(v), 32'(words));
            chk($sformatf("rnd%0d_underrun", it), 32'(un), 32'(und));
            chk($sformatf("rnd%0d_frame_err", it), 32'(e), 32'(n % 8 != 0));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
